// File: rtl/mul32_shift_add.sv
// Sequential unsigned shift-and-add multiplier built on a pair of add32 ripple adders.
// One partial product is accumulated per cycle; latency is fixed at WIDTH iterations.

module add32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_o
);

  always_comb begin
    logic carry;
    carry = c_i;
    sum_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    c_o = carry;
  end

endmodule

module mul32_shift_add #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [CW-1:0]        count_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 ready_q;
  logic                 valid_q;
  logic                 busy_q;

  logic [WIDTH-1:0]     lo_sum;
  logic [WIDTH-1:0]     hi_sum;
  logic                 lo_carry;
  logic                 carry_hi_unused;
  logic                 last_iter;

  add32 #(.WIDTH(WIDTH)) u_add_lo (
    .a_i   (acc_q[WIDTH-1:0]),
    .b_i   (mcand_q[WIDTH-1:0]),
    .c_i   (1'b0),
    .sum_o (lo_sum),
    .c_o   (lo_carry)
  );

  // Carry out of the top bit cannot occur: the product of two WIDTH-bit values fits in 2*WIDTH bits.
  add32 #(.WIDTH(WIDTH)) u_add_hi (
    .a_i   (acc_q[2*WIDTH-1:WIDTH]),
    .b_i   (mcand_q[2*WIDTH-1:WIDTH]),
    .c_i   (lo_carry),
    .sum_o (hi_sum),
    .c_o   (carry_hi_unused)
  );

  always_comb begin
    acc_d     = mplier_q[0] ? {hi_sum, lo_sum} : acc_q;
    last_iter = (count_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            count_q  <= '0;
            state_q  <= S_RUN;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        S_RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + CW'(1);
          if (last_iter) begin
            product_q <= acc_d;
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            valid_q   <= 1'b1;
          end
        end
        S_DONE: begin
          if (i_ready) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign busy    = busy_q;
  assign product = product_q;

endmodule

// File: tb/tb_mul32_shift_add.sv
// Scoreboard bench for mul32_shift_add: driver pushes a*b expectations, a negedge monitor
// pops and compares on every product handshake, also checking latency and busy duration.

module tb_mul32_shift_add;

  localparam int unsigned W = 32;

  logic           clk;
  logic           rst;
  logic           i_valid;
  logic           o_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           o_valid;
  logic           i_ready;
  logic [2*W-1:0] product;
  logic           busy;

  mul32_shift_add #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .a       (a),
    .b       (b),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .product (product),
    .busy    (busy)
  );

  typedef struct {
    logic [63:0] exp;
    int          acc_cyc;
  } txn_t;

  txn_t sb[$];
  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;
  int   busy_cnt = 0;
  bit   seen = 0;
  bit   ready_chk = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples at negedge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt  = 0;
      seen      = 0;
      ready_chk = 0;
    end else begin
      if (ready_chk) begin
        check("o_ready_after_handshake", 64'(o_ready), 64'd1);
        ready_chk = 0;
      end
      if (busy) busy_cnt++;
      if (o_valid && !seen) begin
        seen = 1;
        check("o_ready_low_in_done", 64'(o_ready), 64'd0);
        check("busy_cycles", 64'(busy_cnt), 64'(W));
        busy_cnt = 0;
        if (sb.size() == 0) check("unexpected_o_valid", 64'd1, 64'd0);
        else check("latency", 64'(cyc - sb[0].acc_cyc), 64'(W));
      end
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          check("product_without_request", 64'd1, 64'd0);
        end else begin
          check("product", product, sb[0].exp);
          void'(sb.pop_front());
        end
        seen      = 0;
        ready_chk = 1;
      end
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    txn_t t;
    n = 0;
    @(posedge clk); #1;
    while (!o_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!o_ready) begin
      check("o_ready_timeout", 64'd0, 64'd1);
    end else begin
      a = x;
      b = y;
      i_valid = 1'b1;
      t.exp = 64'(x) * 64'(y);
      t.acc_cyc = cyc + 1;
      sb.push_back(t);
      @(posedge clk); #1;
      i_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || o_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] held;
    logic [W-1:0] dir_a [5];
    logic [W-1:0] dir_b [5];
    int n;

    dir_a = '{32'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'hDEAD_BEEF};
    dir_b = '{32'd5, 32'hFFFF_FFFF, 32'd2, 32'hDEAD_BEEF, 32'd1};

    rst = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    a = '0;
    b = '0;
    #12;
    check("reset_o_ready", 64'(o_ready), 64'd1);
    check("reset_o_valid", 64'(o_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_product", product, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      send(dir_a[i], dir_b[i]);
      wait_drain();
    end

    // Backpressure: hold the result in DONE while new operands are offered.
    i_ready = 1'b0;
    send(32'h0123_4567, 32'h89AB_CDEF);
    held = 64'h0123_4567 * 64'h89AB_CDEF;
    n = 0;
    while (!o_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_reached_done", 64'(o_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      a = $urandom;
      b = $urandom;
      i_valid = 1'b1;
      @(negedge clk);
      check("bp_o_valid", 64'(o_valid), 64'd1);
      check("bp_o_ready", 64'(o_ready), 64'd0);
      check("bp_product", product, held);
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    wait_drain();

    // Asynchronous reset between edges during the 12th RUN iteration.
    send(32'hCAFE_F00D, 32'h1357_9BDF);
    repeat (11) @(posedge clk);
    #2;
    check("busy_before_reset", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("midrun_o_valid", 64'(o_valid), 64'd0);
    check("midrun_o_ready", 64'(o_ready), 64'd1);
    check("midrun_busy", 64'(busy), 64'd0);
    check("midrun_product", product, 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    send(32'd7, 32'd6);
    wait_drain();

    // Back-to-back random operands with the consumer always ready.
    for (int i = 0; i < 100; i++) begin
      send($urandom, $urandom);
    end
    wait_drain();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
